// File: rtl/or_gate_pkg.sv
// Purpose  : shared defaults and helpers for the OR gate unit.
// Latency  : n/a (package only).
// Backpress: n/a (no flow control).
// Contents : OR_WIDTH_DEF, OR_CNT_W_DEF, or_sat_val().
package or_gate_pkg;

   localparam int OR_WIDTH_DEF = 1;
   localparam int OR_CNT_W_DEF = 16;

   // All-ones value of a cnt_w-bit counter; wide return so callers
   // can narrow it to their own counter width.
   function automatic logic [63:0] or_sat_val(input int cnt_w);
      return (64'd1 << cnt_w) - 64'd1;
   endfunction

endpackage

// File: rtl/or_stage.sv
// Purpose  : WIDTH-bit bitwise OR with a registered copy.
// Latency  : y combinational (0 cycles), y_q 1 cycle.
// Backpress: none; the stage accepts new operands every cycle.
// Ports    : clk, rst (sync, active-high) | a, b operands | y = a|b, y_q = registered y.
module or_stage
   import or_gate_pkg::*;
#(
   parameter int WIDTH = OR_WIDTH_DEF
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   output logic [WIDTH-1:0] y,
   output logic [WIDTH-1:0] y_q
);

   logic [WIDTH-1:0] w_y;
   logic [WIDTH-1:0] r_y_q;

   // Plain OR: X/Z follows the language's OR semantics.
   assign w_y = a | b;

   always_ff @(posedge clk) begin
      if (rst) begin
         r_y_q <= '0;
      end else begin
         r_y_q <= w_y;
      end
   end

   assign y   = w_y;
   assign y_q = r_y_q;

endmodule

// File: rtl/or_gate_unit.sv
// Purpose  : OR of two vectors with registered copy, reduction flag, optional hit counter.
// Latency  : y/y_any combinational, y_q and hit_cnt 1 cycle.
// Backpress: none; every cycle is accepted.
// Ports    : clk, rst (sync, active-high) | a, b | y, y_q, y_any
//            | clr, hit_cnt (only when OR_GATE_STATS_EN is defined).
// Config   : `define OR_GATE_STATS_EN to build the saturating hit counter.
module or_gate_unit
   import or_gate_pkg::*;
#(
   parameter int WIDTH = OR_WIDTH_DEF,
   parameter int CNT_W = OR_CNT_W_DEF
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   output logic [WIDTH-1:0] y,
   output logic [WIDTH-1:0] y_q,
`ifdef OR_GATE_STATS_EN
   input  logic             clr,
   output logic [CNT_W-1:0] hit_cnt,
`endif
   output logic             y_any
);

   // Reject nonsensical widths at elaboration; the counter helper is
   // 64 bits wide, so CNT_W must stay below that.
   if (WIDTH < 1 || CNT_W < 1 || CNT_W > 63) begin : g_bad_param
      $error("or_gate_unit: WIDTH must be >= 1 and CNT_W in 1..63");
   end

   logic [WIDTH-1:0] w_y;

   or_stage #(
      .WIDTH (WIDTH)
   ) u_or_stage (
      .clk (clk),
      .rst (rst),
      .a   (a),
      .b   (b),
      .y   (w_y),
      .y_q (y_q)
   );

   assign y     = w_y;
   assign y_any = |w_y;

`ifdef OR_GATE_STATS_EN
   localparam logic [CNT_W-1:0] CNT_SAT = CNT_W'(or_sat_val(CNT_W));

   logic [CNT_W-1:0] r_hit_cnt;

   // rst beats clr beats increment; the counter sticks at all-ones.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_hit_cnt <= '0;
      end else if (clr) begin
         r_hit_cnt <= '0;
      end else if (y_any && (r_hit_cnt != CNT_SAT)) begin
         r_hit_cnt <= r_hit_cnt + 1'b1;
      end
   end

   assign hit_cnt = r_hit_cnt;
`endif

endmodule

// File: tb/tb_or_gate_unit.sv
// Purpose  : self-checking bench for or_gate_unit (WIDTH=1 and WIDTH=8 instances).
// Latency  : checks y/y_any immediately and y_q one edge later via a scoreboard queue.
// Backpress: n/a.
module tb_or_gate_unit;

   logic       clk;
   logic       rst;
   logic       clr;
   logic [0:0] a1, b1, y1, yq1;
   logic       any1;
   logic [7:0] a8, b8, y8, yq8;
   logic       any8;
`ifdef OR_GATE_STATS_EN
   logic [3:0] hit1, hit8;
`endif

   int n_cmp = 0;
   int n_bad = 0;

   typedef struct {
      logic [7:0] a;
      logic [7:0] b;
      logic [7:0] exp_y;
      logic       exp_any;
   } vec_t;

   vec_t       tbl1[4];
   vec_t       tbl8[6];
   logic [7:0] sb1[$];
   logic [7:0] sb8[$];
   logic [7:0] exp_q;
   int         exp_cnt;

   or_gate_unit #(.WIDTH(1), .CNT_W(4)) u_w1 (
      .clk     (clk),
      .rst     (rst),
      .a       (a1),
      .b       (b1),
      .y       (y1),
      .y_q     (yq1),
`ifdef OR_GATE_STATS_EN
      .clr     (clr),
      .hit_cnt (hit1),
`endif
      .y_any   (any1)
   );

   or_gate_unit #(.WIDTH(8), .CNT_W(4)) u_w8 (
      .clk     (clk),
      .rst     (rst),
      .a       (a8),
      .b       (b8),
      .y       (y8),
      .y_q     (yq8),
`ifdef OR_GATE_STATS_EN
      .clr     (clr),
      .hit_cnt (hit8),
`endif
      .y_any   (any8)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic pop_check(input string name, inout logic [7:0] q[$], input logic [7:0] act);
      logic [7:0] e;
      if (q.size() == 0) begin
         n_cmp++;
         n_bad++;
         $display("FAIL %s: scoreboard empty, got %0h", name, act);
      end else begin
         e = q.pop_front();
         check(name, 64'(act), 64'(e));
      end
   endtask

   initial begin
      // Truth table for WIDTH=1 (bit 0 only) and assorted 8-bit patterns.
      tbl1[0] = '{8'h00, 8'h00, 8'h00, 1'b0};
      tbl1[1] = '{8'h00, 8'h01, 8'h01, 1'b1};
      tbl1[2] = '{8'h01, 8'h00, 8'h01, 1'b1};
      tbl1[3] = '{8'h01, 8'h01, 8'h01, 1'b1};
      tbl8[0] = '{8'hA0, 8'h05, 8'hA5, 1'b1};
      tbl8[1] = '{8'h00, 8'h00, 8'h00, 1'b0};
      tbl8[2] = '{8'h0F, 8'hF0, 8'hFF, 1'b1};
      tbl8[3] = '{8'h81, 8'h00, 8'h81, 1'b1};
      tbl8[4] = '{8'h00, 8'h40, 8'h40, 1'b1};
      tbl8[5] = '{8'h3C, 8'h3C, 8'h3C, 1'b1};

      rst = 1'b1; clr = 1'b0;
      a1 = '0; b1 = '0; a8 = '0; b8 = '0;

      // Reset state.
      @(posedge clk); #1;
      check("rst_yq1", 64'(yq1), 64'h0);
      check("rst_yq8", 64'(yq8), 64'h0);
`ifdef OR_GATE_STATS_EN
      check("rst_hit1", 64'(hit1), 64'h0);
      check("rst_hit8", 64'(hit8), 64'h0);
`endif

      // Reset held while a=1: y live, y_q forced to 0.
      @(negedge clk);
      a1 = 1'b1;
      #1;
      check("y_in_rst", 64'(y1), 64'h1);
      check("any_in_rst", 64'(any1), 64'h1);
      @(posedge clk); #1;
      check("yq_in_rst", 64'(yq1), 64'h0);

      // First edge after release captures a|b and may count.
      @(negedge clk);
      rst = 1'b0;
      sb1.push_back(8'h01);
      @(posedge clk); #1;
      pop_check("yq_after_rst", sb1, {7'd0, yq1});
`ifdef OR_GATE_STATS_EN
      check("hit_after_rst", 64'(hit1), 64'h1);
`endif

      // WIDTH=1 truth table, each pattern held 50 ns.
      for (int i = 0; i < 4; i++) begin
         a1 = tbl1[i].a[0:0];
         b1 = tbl1[i].b[0:0];
         #50;
         check($sformatf("tt_y[%0d]", i), 64'(y1), 64'(tbl1[i].exp_y[0]));
         check($sformatf("tt_any[%0d]", i), 64'(any1), 64'(tbl1[i].exp_any));
      end

      // WIDTH=8: y immediate, y_q one edge later through the scoreboard.
      for (int i = 0; i < 6; i++) begin
         @(negedge clk);
         a8 = tbl8[i].a;
         b8 = tbl8[i].b;
         sb8.push_back(tbl8[i].exp_y);
         #1;
         check($sformatf("w8_y[%0d]", i), 64'(y8), 64'(tbl8[i].exp_y));
         check($sformatf("w8_any[%0d]", i), 64'(any8), 64'(tbl8[i].exp_any));
         @(posedge clk); #1;
         pop_check($sformatf("w8_yq[%0d]", i), sb8, yq8);
      end

      // Back-to-back changes: y_q must lag by exactly one edge.
      @(negedge clk);
      a8 = 8'h12; b8 = 8'h21;
      exp_q = 8'h33;
      sb8.push_back(exp_q);
      @(posedge clk); #1;
      pop_check("w8_b2b0", sb8, yq8);
      a8 = 8'h00; b8 = 8'h80;
      sb8.push_back(8'h80);
      #1;
      check("w8_b2b_hold", 64'(yq8), 64'h33);
      @(posedge clk); #1;
      pop_check("w8_b2b1", sb8, yq8);

`ifdef OR_GATE_STATS_EN
      // clr wins over an active y_any.
      @(negedge clk);
      clr = 1'b1; a1 = 1'b1; b1 = 1'b0;
      @(posedge clk); #1;
      check("clr_prio", 64'(hit1), 64'h0);
      exp_cnt = 0;

      // Saturation at 15 over 20 counting cycles.
      @(negedge clk);
      clr = 1'b0;
      for (int i = 0; i < 20; i++) begin
         @(posedge clk); #1;
         exp_cnt = (exp_cnt < 15) ? exp_cnt + 1 : 15;
         if (i == 4 || i == 14 || i == 19)
            check($sformatf("sat_cnt[%0d]", i), 64'(hit1), 64'(exp_cnt));
      end

      // Idle input: counter holds.
      @(negedge clk);
      a1 = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      check("sat_hold", 64'(hit1), 64'(exp_cnt));

      // Reset with clr low and y_any high still zeroes everything.
      @(negedge clk);
      rst = 1'b1; clr = 1'b0; a1 = 1'b1;
      @(posedge clk); #1;
      check("rst_hit", 64'(hit1), 64'h0);
      check("rst_yq_late", 64'(yq1), 64'h0);
      @(negedge clk);
      rst = 1'b0;
`endif

      @(posedge clk); #1;
      check("sb_drained", 64'(sb1.size() + sb8.size()), 64'h0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
